cnn_stage_sequencer: RTL and testbench
======================================

Name: cnn_stage_sequencer

Overview:
Top-level layer controller for the CNN datapath. It runs conv → ReLU → pool once per filter-group pass, for NUM_PASSES passes, by driving the stage enables and collecting each stage's done flag. The ReLU stage zeroes its outputs whenever its enable is low, so the sequencer holds upstream enables high until the downstream stage has captured its data. It adds a per-stage watchdog, an abort path and a cycle counter for performance measurement.

Parameters:
NUM_PASSES, 4, number of conv/relu/pool passes per start (≥1)
TIMEOUT_CYCLES, 1024, maximum cycles allowed in one stage before error (≥4)
PASS_W, $clog2(NUM_PASSES) min 1, width of pass_idx

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  begin sequence; sampled in IDLE only
abort  in  1  return to IDLE next cycle from any state
conv_done  in  1  conv stage done
relu_done  in  1  relu stage done (registered, 1 cycle after relu_enable)
pool_done  in  1  pool stage done
conv_enable  out  1  conv stage enable
relu_enable  out  1  relu stage enable
pool_enable  out  1  pool stage enable
pass_idx  out  PASS_W  current pass number, selects filter group
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when all passes complete
error  out  1  watchdog fired; held until abort or reset
err_code  out  2  0 none, 1 conv, 2 relu, 3 pool timeout
total_cycles  out  32  busy cycles of last/current run; saturates at all-ones

Behaviour:
- All outputs registered. While rst=0: state IDLE, every output 0, counters 0.
- States: IDLE, CONV, RELU, POOL, NEXT, FINISH, ERROR.
- IDLE: start=1 → CONV at the next edge; pass_idx←0, total_cycles←0, busy←1. start seen outside IDLE is ignored.
- Enables by state:
  - CONV: conv_enable=1.
  - RELU: conv_enable=1, relu_enable=1.
  - POOL: all three enables 1.
  - IDLE, NEXT, FINISH, ERROR: all enables 0.
- Done guard: a stage's done input is accepted only when the stage cycle count is ≥1, i.e. not in the stage's first cycle. This rejects stale done flags.
- Stage transitions: CONV+conv_done → RELU; RELU+relu_done → POOL; POOL+pool_done → NEXT.
- NEXT (1 cycle): all enables drop, which clears the downstream stage outputs.
  - If pass_idx == NUM_PASSES-1 → FINISH.
  - Otherwise pass_idx increments and the next state is CONV.
- FINISH (1 cycle): done=1, busy←0 at exit, → IDLE. pass_idx holds its last value until the next start.
- Minimum pass length: 7 cycles (CONV 2, RELU 2, POOL 2, NEXT 1).
- Watchdog: the stage counter clears on every state change. If it reaches TIMEOUT_CYCLES-1 in CONV/RELU/POOL without an accepted done → ERROR.
  - err_code is set to the stage code (1/2/3); error=1, busy=0, enables 0.
  - ERROR is held until abort.
  - If done and timeout occur in the same cycle, done wins.
- abort=1 in any state → IDLE next edge, with enables, busy, error and err_code cleared. If abort and start are both high in IDLE, abort wins and the block stays in IDLE.
- total_cycles increments on every cycle busy=1 and saturates; it holds its value after FINISH or abort.
- Reset mid-run: immediate asynchronous return to reset values; no pulse on done.

Decomposition:
- Package cnn_ctrl_pkg:
  - state enum (3-bit)
  - err_code localparams (ERR_NONE/CONV/RELU/POOL)
  - default NUM_PASSES and TIMEOUT_CYCLES
- Sub-module stage_watchdog: clear input, count enable, expired output, TIMEOUT_CYCLES parameter. The FSM, pass counter and perf counter stay in the top module.

Test Plan:
- Single-cycle-response stubs (done one cycle after enable), NUM_PASSES=4, start pulse → pass_idx 0,1,2,3; done pulses 28 cycles after the CONV entry cycle; total_cycles=29 (busy cycles including FINISH).
- conv_done held high constantly → CONV still lasts exactly 2 cycles per pass (guard); no stage skipped.
- relu_done never asserted, TIMEOUT_CYCLES=16 → ERROR entered 16 cycles after RELU entry; err_code=2, error=1, enables 0; abort → IDLE, error=0.
- abort during POOL of pass 2 → next cycle IDLE, all enables 0, busy 0, no done pulse; a following start restarts at pass_idx=0.
- Assert rst=0 asynchronously mid-CONV, between clock edges → outputs 0 immediately; start at the same time as abort in IDLE → stays IDLE.
- Check relu_enable is high in every cycle pool_enable is high, and conv_enable is high in every cycle relu_enable is high (assertion across all scenarios).

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and defaults for the CNN layer controller: FSM state encoding,
// watchdog error codes and default pass/timeout parameters.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_RELU   = 3'd2,
    ST_POOL   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CONV = 2'd1;
  localparam logic [1:0] ERR_RELU = 2'd2;
  localparam logic [1:0] ERR_POOL = 2'd3;

  localparam int DEFAULT_NUM_PASSES     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cnn_stage_sequencer_watchdog.sv
// Per-stage cycle counter: cleared on every state change, flags expiry when a
// stage has run TIMEOUT_CYCLES-1 cycles, and reports whether the stage is past its first cycle.
module stage_watchdog
  import cnn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic armed,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // armed gates done inputs so a flag left over from the previous stage is ignored
  assign armed   = (count_q != '0);
  assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Layer controller: sequences conv -> relu -> pool for NUM_PASSES filter-group passes,
// keeping upstream enables high until downstream stages have captured their data.
module cnn_stage_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_PASSES     = DEFAULT_NUM_PASSES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int PASS_W         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              conv_done,
  input  logic              relu_done,
  input  logic              pool_done,
  output logic              conv_enable,
  output logic              relu_enable,
  output logic              pool_enable,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [31:0]       total_cycles
);

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_e            state_q, state_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       total_q, total_d;
  logic              conv_en_q, conv_en_d;
  logic              relu_en_q, relu_en_d;
  logic              pool_en_q, pool_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic in_stage;
  logic wd_clear;
  logic wd_armed;
  logic wd_expired;

  assign in_stage = (state_q == ST_CONV) || (state_q == ST_RELU) || (state_q == ST_POOL);
  assign wd_clear = (state_d != state_q);

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count_en(in_stage),
    .armed   (wd_armed),
    .expired (wd_expired)
  );

  // An accepted done outranks a watchdog expiry landing in the same cycle
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    err_code_d = err_code_q;
    total_d    = total_q;

    if (busy_q && (total_q != '1)) begin
      total_d = total_q + 32'd1;
    end

    if (abort) begin
      state_d    = ST_IDLE;
      err_code_d = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CONV;
            pass_d  = '0;
            total_d = '0;
          end
        end
        ST_CONV: begin
          if (conv_done && wd_armed) begin
            state_d = ST_RELU;
          end else if (wd_expired) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_CONV;
          end
        end
        ST_RELU: begin
          if (relu_done && wd_armed) begin
            state_d = ST_POOL;
          end else if (wd_expired) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_RELU;
          end
        end
        ST_POOL: begin
          if (pool_done && wd_armed) begin
            state_d = ST_NEXT;
          end else if (wd_expired) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_POOL;
          end
        end
        ST_NEXT: begin
          if (pass_q == LAST_PASS) begin
            state_d = ST_FINISH;
          end else begin
            pass_d  = pass_q + 1'b1;
            state_d = ST_CONV;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_IDLE;
      endcase
    end

    conv_en_d = (state_d == ST_CONV) || (state_d == ST_RELU) || (state_d == ST_POOL);
    relu_en_d = (state_d == ST_RELU) || (state_d == ST_POOL);
    pool_en_d = (state_d == ST_POOL);
    busy_d    = conv_en_d || (state_d == ST_NEXT) || (state_d == ST_FINISH);
    done_d    = (state_d == ST_FINISH);
    error_d   = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pass_q     <= '0;
      err_code_q <= ERR_NONE;
      total_q    <= '0;
      conv_en_q  <= 1'b0;
      relu_en_q  <= 1'b0;
      pool_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      err_code_q <= err_code_d;
      total_q    <= total_d;
      conv_en_q  <= conv_en_d;
      relu_en_q  <= relu_en_d;
      pool_en_q  <= pool_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign conv_enable  = conv_en_q;
  assign relu_enable  = relu_en_q;
  assign pool_enable  = pool_en_q;
  assign pass_idx     = pass_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Scoreboard bench for cnn_stage_sequencer: stage stubs with programmable latency,
// an arithmetic timing model feeding an expected-event queue, and an independent monitor.
module tb_cnn_stage_sequencer;

  localparam int NP = 4;
  localparam int TO = 16;

  logic        clk, rst, start, abort;
  logic        conv_done, relu_done, pool_done;
  logic        conv_enable, relu_enable, pool_enable;
  logic [1:0]  pass_idx;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] total_cycles;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int lat_conv = 1, lat_relu = 1, lat_pool = 1;
  int conv_cnt, relu_cnt, pool_cnt;

  typedef struct {
    bit is_err;
    int cycle;
    int pass;
    int code;
    int total_evt;
    int total_fin;
  } exp_t;

  exp_t sb[$];
  bit   pend = 0;
  int   pend_fin = 0;
  bit   err_prev = 0;

  cnn_stage_sequencer #(
    .NUM_PASSES    (NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .conv_done   (conv_done),
    .relu_done   (relu_done),
    .pool_done   (pool_done),
    .conv_enable (conv_enable),
    .relu_enable (relu_enable),
    .pool_enable (pool_enable),
    .pass_idx    (pass_idx),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .total_cycles(total_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stage stubs: done rises once the enable has been high for lat cycles (lat=0 means always high)
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_cnt <= 0;
      relu_cnt <= 0;
      pool_cnt <= 0;
    end else begin
      conv_cnt <= conv_enable ? ((conv_cnt < 1000) ? conv_cnt + 1 : conv_cnt) : 0;
      relu_cnt <= relu_enable ? ((relu_cnt < 1000) ? relu_cnt + 1 : relu_cnt) : 0;
      pool_cnt <= pool_enable ? ((pool_cnt < 1000) ? pool_cnt + 1 : pool_cnt) : 0;
    end
  end

  assign conv_done = (conv_cnt >= lat_conv);
  assign relu_done = (relu_cnt >= lat_relu);
  assign pool_done = (pool_cnt >= lat_pool);

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int stage_len(input int lat);
    return ((lat < 1) ? 1 : lat) + 1;
  endfunction

  // Reference timing: each stage lasts until its done is accepted (never in its first cycle),
  // a pass adds one gap cycle, and a stage that cannot finish by cycle TO-1 times out.
  task automatic push_expected(input int lc, input int lr, input int lp, input int entry);
    int   lats[3];
    int   t;
    exp_t e;
    lats = '{lc, lr, lp};
    t = 0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 3; k++) begin
        if (((lats[k] < 1) ? 1 : lats[k]) > TO - 1) begin
          e.is_err    = 1;
          e.cycle     = entry + t + TO;
          e.pass      = p;
          e.code      = k + 1;
          e.total_evt = t + TO;
          e.total_fin = t + TO;
          sb.push_back(e);
          return;
        end
        t += stage_len(lats[k]);
      end
      t += 1;
    end
    e.is_err    = 0;
    e.cycle     = entry + t;
    e.pass      = NP - 1;
    e.code      = 0;
    e.total_evt = t;
    e.total_fin = t + 1;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int lc, input int lr, input int lp);
    lat_conv = lc;
    lat_relu = lr;
    lat_pool = lp;
    push_expected(lc, lr, lp, cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_pass_idx", pass_idx, 0);
    checkOutput("start_conv_en", conv_enable, 1);
    checkOutput("start_relu_en", relu_enable, 0);
    checkOutput("start_total", total_cycles, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || pend) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", sb.size() + int'(pend), 0);
    sb.delete();
    pend = 0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    pend = 0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_enables", {conv_enable, relu_enable, pool_enable}, 0);
    checkOutput("abort_error", error, 0);
    checkOutput("abort_err_code", err_code, 0);
    checkOutput("abort_done", done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_enables"}, {conv_enable, relu_enable, pool_enable}, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_err_code"}, err_code, 0);
    checkOutput({tag, "_pass_idx"}, pass_idx, 0);
    checkOutput({tag, "_total"}, total_cycles, 0);
  endtask

  // Monitor: enable nesting every cycle, and every done pulse / error rise against the queue
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pool_enable) checkOutput("pool_needs_relu", relu_enable, 1);
        if (relu_enable) checkOutput("relu_needs_conv", conv_enable, 1);
        if (pend) begin
          checkOutput("total_after_event", total_cycles, pend_fin);
          checkOutput("done_single_cycle", done, 0);
          pend = 0;
        end
        if (done || (error && !err_prev)) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_event", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("event_cycle", cyc, e.cycle);
            checkOutput("event_error", error, e.is_err);
            checkOutput("event_done", done, !e.is_err);
            checkOutput("event_pass_idx", pass_idx, e.pass);
            checkOutput("event_err_code", err_code, e.code);
            checkOutput("event_busy", busy, !e.is_err);
            checkOutput("event_enables", {conv_enable, relu_enable, pool_enable}, 0);
            checkOutput("event_total", total_cycles, e.total_evt);
            pend     = 1;
            pend_fin = e.total_fin;
          end
        end
      end else begin
        pend = 0;
      end
      err_prev = error;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    int stage;
    int l[3];
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single-cycle stubs: 7-cycle passes, done 28 cycles after CONV entry, 29 busy cycles
    applyStimulus(1, 1, 1);
    wait_drain(200);
    checkOutput("directed_total", total_cycles, 29);
    checkOutput("directed_pass_idx_holds", pass_idx, NP - 1);
    checkOutput("directed_busy", busy, 0);

    // conv_done stuck high: the guard still forces two CONV cycles per pass
    applyStimulus(0, 1, 1);
    wait_drain(200);

    // Done arriving on the very cycle the watchdog expires must win
    applyStimulus(TO - 1, 1, 0);
    wait_drain(400);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      wait_drain(400);
    end

    // relu_done never arrives: ERROR 16 cycles after RELU entry, held until abort
    applyStimulus(1, 500, 1);
    wait_drain(200);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("err_held_error", error, 1);
    checkOutput("err_held_code", err_code, 2);
    checkOutput("err_held_busy", busy, 0);
    checkOutput("err_held_enables", {conv_enable, relu_enable, pool_enable}, 0);
    do_abort();
    checkOutput("err_abort_total_holds", total_cycles, 18);

    for (int i = 0; i < 3; i++) begin
      stage = $urandom_range(0, 2);
      for (int k = 0; k < 3; k++) l[k] = $urandom_range(0, 4);
      l[stage] = TO + $urandom_range(0, 20);
      applyStimulus(l[0], l[1], l[2]);
      wait_drain(300);
      checkOutput("rand_timeout_code", err_code, stage + 1);
      do_abort();
    end

    // Abort in POOL of pass 2: immediate IDLE, no done, restart from pass 0
    applyStimulus(1, 1, 1);
    n = 0;
    while (!(pool_enable && pass_idx == 2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_pool_pass2", int'(pool_enable && pass_idx == 2), 1);
    do_abort();
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_abort_no_done", done, 0);
    end
    applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    wait_drain(300);

    // Asynchronous reset between clock edges during CONV
    applyStimulus(3, 1, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    pend = 0;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_conv_en", conv_enable, 0);
    @(negedge clk);
    checkOutput("start_abort_still_idle", busy, 0);

    applyStimulus(2, 0, 3);
    wait_drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
